// File: rtl/egress_drain_reader_if.sv
// Reader-side bundle for the D0/D1 destination FIFOs and the forwarded output stream.
// The master modport is the drain reader; the slave modport is the FIFO/downstream side.
interface egress_drain_reader_if #(
    parameter int BW = 6
);
    logic          D0_empty;
    logic          D1_empty;
    logic [BW-1:0] D0_data_out;
    logic [BW-1:0] D1_data_out;
    logic          D0_rd;
    logic          D1_rd;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_src;

    modport master (
        input  D0_empty, D1_empty, D0_data_out, D1_data_out, out_ready,
        output D0_rd, D1_rd, out_valid, out_data, out_src
    );

    modport slave (
        output D0_empty, D1_empty, D0_data_out, D1_data_out, out_ready,
        input  D0_rd, D1_rd, out_valid, out_data, out_src
    );
endinterface

// File: rtl/egress_drain_reader.sv
// Drains the D0/D1 destination FIFOs onto one valid/ready stream with per-source counters and sticky errors.
// Define DRAIN_STRICT_PRIO_EN for fixed D0 priority; the default build arbitrates round-robin.
module egress_drain_reader #(
    parameter int BW = 6,
    parameter int CW = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    egress_drain_reader_if.master bus,
    input  logic                  D0_error_output,
    input  logic                  D1_error_output,
    output logic [CW-1:0]         D0_count,
    output logic [CW-1:0]         D1_count,
    output logic [1:0]            err_sticky,
    output logic                  idle_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   sel_p0;
    logic   last_src;
    logic   pick;
    logic   grant;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        return v + CW'(1);
    endfunction

    always_comb begin
        pick      = 1'b0;
        grant     = 1'b0;
        state_nxt = state;
`ifdef DRAIN_STRICT_PRIO_EN
        pick = bus.D0_empty;
`else
        if (!bus.D0_empty && !bus.D1_empty)
            pick = ~last_src;
        else
            pick = bus.D0_empty;
`endif
        // Only one read may be in flight, so a new pop is legal only when nothing is pending or held.
        grant = reset_L && !init && !(bus.D0_empty && bus.D1_empty) &&
                ((state == IDLE) || ((state == HOLD) && bus.out_ready));
        case (state)
            IDLE:    if (grant) state_nxt = PEND;
            PEND:    state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = grant ? PEND : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (init)
            state_nxt = IDLE;
    end

    assign bus.D0_rd = grant & ~pick;
    assign bus.D1_rd = grant & pick;
    assign idle_out  = (state == IDLE) && bus.D0_empty && bus.D1_empty;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel_p0        <= 1'b0;
            last_src      <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= 1'b0;
            D0_count      <= '0;
            D1_count      <= '0;
            err_sticky    <= 2'b00;
        end else if (init) begin
            bus.out_valid <= 1'b0;
            D0_count      <= '0;
            D1_count      <= '0;
            err_sticky    <= 2'b00;
        end else begin
            err_sticky <= err_sticky | {D1_error_output, D0_error_output};
            if (grant) begin
                sel_p0   <= pick;
                last_src <= pick;
            end
            // PEND -> HOLD: FIFO read data is valid one cycle after the pop.
            case (state)
                PEND: begin
                    bus.out_data  <= sel_p0 ? bus.D1_data_out : bus.D0_data_out;
                    bus.out_src   <= sel_p0;
                    bus.out_valid <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (bus.out_src)
                            D1_count <= wrap_inc(D1_count);
                        else
                            D0_count <= wrap_inc(D0_count);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_egress_drain_reader.sv
// Bench for egress_drain_reader: FIFO models feed the DUT; a scoreboard checks data, arbitration, counters and flags.
module tb_egress_drain_reader;
    localparam int BW = 6;
    localparam int CW = 8;
`ifdef DRAIN_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    typedef struct packed {
        logic          src;
        logic [BW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          init = 1'b0;
    logic          d0_err = 1'b0;
    logic          d1_err = 1'b0;
    logic [CW-1:0] D0_count, D1_count;
    logic [1:0]    err_sticky;
    logic          idle_out;

    egress_drain_reader_if #(.BW(BW)) bus();

    egress_drain_reader #(.BW(BW), .CW(CW)) dut (
        .clk(clk), .reset_L(reset_L), .init(init), .bus(bus),
        .D0_error_output(d0_err), .D1_error_output(d1_err),
        .D0_count(D0_count), .D1_count(D1_count),
        .err_sticky(err_sticky), .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // FIFO contents (hardware side) and scoreboard queues
    logic [BW-1:0] q0[$], q1[$];
    logic [BW-1:0] exp0[$], exp1[$];
    word_t         exp_out[$];
    logic          src_log[$];
    int            rd_log[$];

    always @(posedge clk) begin
        if (bus.D0_rd && q0.size() > 0) bus.D0_data_out <= q0.pop_front();
        if (bus.D1_rd && q1.size() > 0) bus.D1_data_out <= q1.pop_front();
        bus.D0_empty <= (q0.size() == 0);
        bus.D1_empty <= (q1.size() == 0);
    end

    task automatic push(input int f, input logic [BW-1:0] d);
        if (f == 0) begin q0.push_back(d); exp0.push_back(d); end
        else        begin q1.push_back(d); exp1.push_back(d); end
    endtask

    // Reference model: counters, sticky flags, round-robin history, in-flight word
    int            cyc = 0;
    int            last_rd_cyc = 0;
    logic [CW-1:0] m_cnt0 = '0, m_cnt1 = '0;
    logic [1:0]    m_err = 2'b00;
    logic          m_last = 1'b1;
    logic          prev_hold = 1'b0, prev_valid = 1'b0, prev_src = 1'b0;
    logic [BW-1:0] prev_data = '0;

    always @(negedge clk) begin
        word_t w;
        logic  src, want;
        cyc++;
        if (!reset_L) begin
            m_cnt0 = '0; m_cnt1 = '0; m_err = 2'b00; m_last = 1'b1;
            exp_out.delete(); prev_hold = 1'b0; prev_valid = 1'b0;
        end
        check("D0_count", D0_count, m_cnt0);
        check("D1_count", D1_count, m_cnt1);
        check("err_sticky", err_sticky, m_err);
        if (!reset_L) begin
            check("valid_in_reset", bus.out_valid, 1'b0);
        end else begin
            if (prev_hold) begin
                check("hold_valid", bus.out_valid, 1'b1);
                check("hold_data", bus.out_data, prev_data);
                check("hold_src", bus.out_src, prev_src);
            end
            if (bus.out_valid && !prev_valid) check("rd_to_valid_latency", cyc - last_rd_cyc, 2);
            prev_valid = bus.out_valid;
            if (init) begin
                m_cnt0 = '0; m_cnt1 = '0; m_err = 2'b00;
                exp_out.delete(); prev_hold = 1'b0; prev_valid = 1'b0;
            end else begin
                m_err = m_err | {d1_err, d0_err};
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (exp_out.size() == 0) check("out_pending", 0, 1);
                        else begin
                            w = exp_out.pop_front();
                            check("out_data", bus.out_data, w.data);
                            check("out_src", bus.out_src, w.src);
                            src_log.push_back(bus.out_src);
                            if (bus.out_src) m_cnt1 = m_cnt1 + 1'b1;
                            else             m_cnt0 = m_cnt0 + 1'b1;
                        end
                    end else begin
                        check("no_rd_while_held", {bus.D0_rd, bus.D1_rd}, 2'b00);
                    end
                end
                if (bus.D0_rd || bus.D1_rd) begin
                    check("single_rd", bus.D0_rd & bus.D1_rd, 1'b0);
                    src = bus.D1_rd;
                    check("rd_nonempty", src ? bus.D1_empty : bus.D0_empty, 1'b0);
                    if (!bus.D0_empty && !bus.D1_empty) begin
                        want = STRICT ? 1'b0 : !m_last;
                        check("arbitration", src, want);
                    end
                    m_last = src;
                    last_rd_cyc = cyc;
                    rd_log.push_back(cyc);
                    if (src && exp1.size() > 0)       exp_out.push_back({1'b1, exp1.pop_front()});
                    else if (!src && exp0.size() > 0) exp_out.push_back({1'b0, exp0.pop_front()});
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
                prev_src  = bus.out_src;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int i = 0;
        while (!(exp0.size() == 0 && exp1.size() == 0 && exp_out.size() == 0 && !bus.out_valid)
               && i < budget) begin
            tick();
            i++;
        end
        check({name, "_drained"}, i < budget, 1'b1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int i = 0;
        while (!bus.out_valid && i < budget) begin
            tick();
            i++;
        end
        check({name, "_valid"}, bus.out_valid, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic          exp_seq [4];
        logic [CW-1:0] c0, c1, e;
        logic [BW-1:0] held;
        int            i;
        bus.out_ready = 1'b0;
`ifdef DRAIN_STRICT_PRIO_EN
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 6'd0);
        check("rst_out_src", bus.out_src, 1'b0);
        check("rst_rd", {bus.D0_rd, bus.D1_rd}, 2'b00);
        reset_L = 1'b1;
        tick();
        check("rst_idle_out", idle_out, 1'b1);

        // three D0 words, downstream always ready
        bus.out_ready = 1'b1;
        rd_log.delete(); src_log.delete();
        push(0, 6'b11_0001); push(0, 6'b11_1111); push(0, 6'b11_1100);
        wait_drain(60, "t1");
        check("t1_rd_pulses", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check("t1_rd_gap0", rd_log[1] - rd_log[0], 2);
            check("t1_rd_gap1", rd_log[2] - rd_log[1], 2);
        end
        check("t1_D0_count", D0_count, 8'd3);
        check("t1_idle_out", idle_out, 1'b1);

        // both FIFOs hold two words from a fresh reset
        reset_L = 1'b0; tick(); reset_L = 1'b1; tick();
        src_log.delete();
        push(0, 6'b00_0011); push(0, 6'b01_0110); push(1, 6'b10_1001); push(1, 6'b11_1010);
        wait_drain(60, "t2");
        check("t2_words", src_log.size(), 4);
        for (int k = 0; k < 4 && k < src_log.size(); k++) check("t2_src_order", src_log[k], exp_seq[k]);

        // backpressure: word held for 5 cycles with D1 waiting
        bus.out_ready = 1'b0;
        c0 = D0_count;
        push(0, 6'b11_0101);
        wait_valid(20, "t3");
        push(1, 6'b01_1000);
        repeat (5) begin
            tick();
            check("t3_data_stable", bus.out_data, 6'b11_0101);
            check("t3_no_rd", {bus.D0_rd, bus.D1_rd}, 2'b00);
            check("t3_count_stable", D0_count, c0);
        end
        bus.out_ready = 1'b1;
        tick();
        e = c0 + 1'b1;
        check("t3_count_inc", D0_count, e);
        wait_drain(40, "t3");

        // 2^CW+1 words from D1 wrap the counter
        c1 = D1_count;
        for (i = 0; i < (1 << CW) + 1; i++) push(1, BW'($urandom));
        wait_drain(1200, "t4");
        e = c1 + 1'b1;
        check("t4_D1_wrap", D1_count, e);

        // sticky error, then init while a read is pending (with a coincident D0 error)
        d1_err = 1'b1; tick(); d1_err = 1'b0; tick();
        check("t5_err_set", err_sticky, 2'b10);
        repeat (3) tick();
        check("t5_err_hold", err_sticky, 2'b10);
        push(0, 6'b10_0110);
        i = 0;
        while (!bus.D0_rd && i < 10) begin tick(); i++; end
        check("t5_rd_seen", bus.D0_rd, 1'b1);
        tick();
        init = 1'b1; d0_err = 1'b1;
        tick();
        init = 1'b0; d0_err = 1'b0;
        check("t5_init_err", err_sticky, 2'b00);
        check("t5_init_counts", {D0_count, D1_count}, 16'd0);
        check("t5_init_valid", bus.out_valid, 1'b0);
        repeat (3) begin
            tick();
            check("t5_dropped", bus.out_valid, 1'b0);
        end
        check("t5_idle_out", idle_out, 1'b1);

        // asynchronous reset while a word is held
        push(1, 6'b00_1111); push(1, 6'b11_0000);
        wait_drain(40, "t6");
        bus.out_ready = 1'b0;
        push(1, 6'b01_0101);
        wait_valid(20, "t6");
        held = bus.out_data;
        check("t6_held_data", held, 6'b01_0101);
        #2 reset_L = 1'b0;
        #1;
        check("t6_async_valid", bus.out_valid, 1'b0);
        check("t6_async_counts", {D0_count, D1_count}, 16'd0);
        tick();
        reset_L = 1'b1;
        tick();

        // randomized traffic with backpressure, error pulses and occasional init
        repeat (400) begin
            if ($urandom_range(2) == 0) push(0, BW'($urandom));
            if ($urandom_range(2) == 0) push(1, BW'($urandom));
            bus.out_ready = ($urandom_range(3) != 0);
            d0_err = ($urandom_range(15) == 0);
            d1_err = ($urandom_range(15) == 0);
            init   = ($urandom_range(59) == 0);
            tick();
        end
        init = 1'b0; d0_err = 1'b0; d1_err = 1'b0; bus.out_ready = 1'b1;
        wait_drain(2000, "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
